// File: rtl/crc_link_scheduler.sv
// Message scheduler for the CRC encode/inject/decode chain: feeds host words to the
// transmitter, drives per-word error vectors, counts receiver beats and runs a watchdog.
module crc_link_scheduler #(
    parameter int MAX_WORDS = 16,
    parameter int TIMEOUT   = 64,
    localparam int LW       = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] msgLen,
    input  logic [1:0]    erMode,
    input  logic          hostValid,
    input  logic [15:0]   hostData,
    output logic          hostReady,
    output logic          dataValid,
    output logic [15:0]   dataIn,
    input  logic          Txbusy,
    input  logic          CWValid,
    output logic [31:0]   erIn,
    output logic          endMsgIn,
    input  logic          dOutValid,
    input  logic          erFree,
    input  logic          endMsgOut,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [LW-1:0] rxCount,
    output logic [LW-1:0] errCount
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_CW,
        ST_END,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] word_idx;
    logic [LW-1:0] msg_len;
    logic [1:0]    mode;
    logic [WW-1:0] wd_cnt;
    logic          len_ok;
    logic          last_word;
    logic          wd_active;
    logic          wd_fire;
    logic [4:0]    bit_idx;
    logic [4:0]    bit_idx_nxt;

    assign len_ok      = (msgLen != '0) && (msgLen <= LW'(MAX_WORDS));
    assign last_word   = (word_idx + LW'(1)) == msg_len;
    assign wd_active   = (state == ST_ISSUE) || (state == ST_WAIT_CW) || (state == ST_DRAIN);
    assign bit_idx     = 5'(word_idx);
    assign bit_idx_nxt = bit_idx + 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wd_fire   = 1'b0;
        case (state)
            ST_IDLE:    if (start && len_ok) state_nxt = ST_FETCH;
            ST_FETCH:   if (hostValid) state_nxt = ST_ISSUE;
            ST_ISSUE:   if (!Txbusy) state_nxt = ST_WAIT_CW;
            ST_WAIT_CW: if (CWValid) state_nxt = last_word ? ST_END : ST_FETCH;
            ST_END:     state_nxt = ST_DRAIN;
            ST_DRAIN:   if (endMsgOut) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // A legitimate exit in the expiry cycle wins over the watchdog.
        if (wd_active && (wd_cnt == WW'(TIMEOUT - 1)) && (state_nxt == state)) begin
            wd_fire   = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        erIn = '0;
        if ((state == ST_ISSUE) || (state == ST_WAIT_CW)) begin
            case (mode)
                2'b01:   erIn = 32'd1 << bit_idx;
                2'b10:   erIn = (32'd1 << bit_idx) | (32'd1 << bit_idx_nxt);
                default: erIn = '0;
            endcase
        end
    end

    assign hostReady = (state == ST_FETCH);
    assign dataValid = (state == ST_ISSUE) && !Txbusy;
    assign endMsgIn  = (state == ST_END);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_idx <= '0;
            msg_len  <= '0;
            mode     <= '0;
            wd_cnt   <= '0;
            dataIn   <= '0;
            timeout  <= 1'b0;
            rxCount  <= '0;
            errCount <= '0;
        end else begin
            wd_cnt <= ((state_nxt != state) || !wd_active) ? '0 : wd_cnt + WW'(1);
            if ((state == ST_IDLE) && (state_nxt == ST_FETCH)) begin
                msg_len  <= msgLen;
                mode     <= erMode;
                word_idx <= '0;
                rxCount  <= '0;
                errCount <= '0;
                timeout  <= 1'b0;
            end
            if ((state == ST_FETCH) && hostValid) begin
                dataIn <= hostData;
            end
            if ((state == ST_WAIT_CW) && CWValid) begin
                word_idx <= word_idx + LW'(1);
            end
            if (wd_fire) begin
                timeout <= 1'b1;
            end
            // Counting is keyed on the current state, so beats in transition cycles still land.
            if ((state != ST_IDLE) && dOutValid) begin
                if (rxCount != '1) rxCount <= rxCount + LW'(1);
                if (!erFree && (errCount != '1)) errCount <= errCount + LW'(1);
            end
        end
    end
endmodule
